// File: rtl/decode_queue_if.sv
// Fetch/dispatch-facing signal bundle for decode_queue.
// Packets are flat PKT_W-bit vectors; the field layout is the packet_t struct inside decode_queue.
interface decode_queue_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
);
  localparam int AW    = $clog2(WIDTH + 1);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PKT_W = 122;

  logic                        flush;
  logic [WIDTH-1:0]            if_valid;
  logic [WIDTH-1:0][31:0]      if_inst;
  logic [WIDTH-1:0][31:0]      if_pc;
  logic [AW-1:0]               if_accept;
  logic [WIDTH-1:0]            ds_valid;
  logic [WIDTH-1:0][PKT_W-1:0] ds_packet;
  logic [AW-1:0]               ds_take;
  logic [CW-1:0]               count;
  logic                        halted;

  modport master (
    output flush, if_valid, if_inst, if_pc, ds_take,
    input  if_accept, ds_valid, ds_packet, count, halted
  );

  modport slave (
    input  flush, if_valid, if_inst, if_pc, ds_take,
    output if_accept, ds_valid, ds_packet, count, halted
  );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane RV32I decode stage feeding a circular buffer of decoded packets,
// with halt/illegal fencing and flush on branch recovery.
module decoder (
  input  logic        valid,
  input  logic [31:0] inst,
  output logic [1:0]  opa_select,
  output logic [1:0]  opb_select,
  output logic [3:0]  op_type,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [4:0]  rd_idx,
  output logic        uses_rd,
  output logic [31:0] immediate,
  output logic        halt,
  output logic        illegal
);
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        bad, is_wfi;

  assign imm_i   = {{20{inst[31]}}, inst[31:20]};
  assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u   = {inst[31:12], 12'b0};
  assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign rs1_idx = inst[19:15];
  assign rs2_idx = inst[24:20];
  assign rd_idx  = inst[11:7];
  assign is_wfi  = (inst == 32'h1050_0073);

  // opa: 0 rs1, 1 pc, 2 zero; opb: 0 rs2, 1 imm, 2 constant 4
  always_comb begin
    opa_select = 2'd0;
    opb_select = 2'd0;
    op_type    = 4'd0;
    uses_rd    = 1'b0;
    immediate  = 32'd0;
    bad        = 1'b0;
    case (inst[6:0])
      7'b0110111: begin opa_select = 2'd2; opb_select = 2'd1; op_type = 4'd6; uses_rd = 1'b1; immediate = imm_u; end
      7'b0010111: begin opa_select = 2'd1; opb_select = 2'd1; op_type = 4'd7; uses_rd = 1'b1; immediate = imm_u; end
      7'b1101111: begin opa_select = 2'd1; opb_select = 2'd2; op_type = 4'd4; uses_rd = 1'b1; immediate = imm_j; end
      7'b1100111: begin
        opa_select = 2'd1; opb_select = 2'd2; op_type = 4'd5; uses_rd = 1'b1; immediate = imm_i;
        bad = (funct3 != 3'd0);
      end
      7'b1100011: begin op_type = 4'd1; immediate = imm_b; bad = (funct3 == 3'd2) || (funct3 == 3'd3); end
      7'b0000011: begin
        opb_select = 2'd1; op_type = 4'd2; uses_rd = 1'b1; immediate = imm_i;
        bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      7'b0100011: begin opb_select = 2'd1; op_type = 4'd3; immediate = imm_s; bad = (funct3 > 3'd2); end
      7'b0010011: begin
        opb_select = 2'd1; uses_rd = 1'b1; immediate = imm_i;
        bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
              ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      7'b0110011: begin
        uses_rd = 1'b1;
        bad = (funct7 != 7'h00) && !((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      7'b1110011: begin op_type = 4'd8; immediate = imm_i; bad = !is_wfi; end
      default:    bad = 1'b1;
    endcase
  end

  assign halt    = valid & is_wfi;
  assign illegal = valid & bad;
endmodule

module decode_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  opa_select;
    logic [1:0]  opb_select;
    logic [3:0]  op_type;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic        uses_rd;
    logic [31:0] immediate;
    logic        halt;
    logic        illegal;
  } packet_t;

  packet_t          dec [WIDTH];
  packet_t          mem [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg;
  logic             halted_reg;
  logic [AW-1:0]    accept, take;
  logic [WIDTH-1:0] lane_ok, stop;
  logic             fence;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign lane_ok[gi]  = &bus.if_valid[gi:0];
      assign dec[gi].pc   = bus.if_pc[gi];
      assign dec[gi].inst = bus.if_inst[gi];
      assign stop[gi]     = dec[gi].halt | dec[gi].illegal;

      decoder u_decoder (
        .valid      (lane_ok[gi]),
        .inst       (bus.if_inst[gi]),
        .opa_select (dec[gi].opa_select),
        .opb_select (dec[gi].opb_select),
        .op_type    (dec[gi].op_type),
        .rs1_idx    (dec[gi].rs1_idx),
        .rs2_idx    (dec[gi].rs2_idx),
        .rd_idx     (dec[gi].rd_idx),
        .uses_rd    (dec[gi].uses_rd),
        .immediate  (dec[gi].immediate),
        .halt       (dec[gi].halt),
        .illegal    (dec[gi].illegal)
      );

      // Head view comes only from registered state, never from the fetch side.
      assign bus.ds_valid[gi]  = (count_reg > CW'(gi));
      assign bus.ds_packet[gi] = mem[head_reg + PW'(gi)];
    end
  endgenerate

  always_comb begin : accept_logic
    int run, lim, room, n, avail;
    run = 0;
    for (int i = 0; i < WIDTH; i++) if (lane_ok[i]) run = i + 1;
    // The oldest fencing lane is the last one allowed in.
    lim = WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) if (stop[i]) lim = i + 1;
    room = DEPTH - int'(count_reg);
    n = run;
    if (lim < n)  n = lim;
    if (room < n) n = room;
    if (!rst_n || bus.flush || halted_reg) n = 0;
    accept = AW'(n);
    avail  = (int'(count_reg) < WIDTH) ? int'(count_reg) : WIDTH;
    take   = (int'(bus.ds_take) < avail) ? bus.ds_take : AW'(avail);
  end

  always_comb begin
    fence = 1'b0;
    for (int i = 0; i < WIDTH; i++) if ((i < int'(accept)) && stop[i]) fence = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      halted_reg <= 1'b0;
    end else if (bus.flush) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      halted_reg <= 1'b0;
    end else begin
      head_reg   <= head_reg + PW'(take);
      tail_reg   <= tail_reg + PW'(accept);
      count_reg  <= count_reg + CW'(accept) - CW'(take);
      halted_reg <= halted_reg | fence;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(accept)) mem[tail_reg + PW'(i)] <= dec[i];
    end
  end

  assign bus.if_accept = accept;
  assign bus.count     = count_reg;
  assign bus.halted    = halted_reg;
endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model
// of acceptance, fencing, flush and in-order dispatch.
module tb_decode_queue;
  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  opa_select;
    logic [1:0]  opb_select;
    logic [3:0]  op_type;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic        uses_rd;
    logic [31:0] immediate;
    logic        halt;
    logic        illegal;
  } pkt_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic        halt;
    logic        ill;
    logic        chk;
  } ent_t;

  // ADDI x1,x2,-5 / ADD x3,x1,x2 / LUI x5,0x12345 / SW x2,8(x1) / JAL x1,16 / LW x4,-8(x3) / WFI / all-zero
  logic [31:0] pool_inst [8] = '{32'hFFB10093, 32'h002081B3, 32'h123452B7, 32'h0020A423,
                                 32'h010000EF, 32'hFF81A203, 32'h10500073, 32'h00000000};
  logic [31:0] pool_imm  [8] = '{32'hFFFFFFFB, 32'h0, 32'h12345000, 32'h8,
                                 32'h10, 32'hFFFFFFF8, 32'h0, 32'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  ent_t  lane [WIDTH];
  ent_t  mq [$];
  ent_t  fq [$];
  logic  m_halted = 1'b0;
  int    last_exp_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t make_ent(input int p, input logic [31:0] pc);
    ent_t e;
    e.pc   = pc;
    e.inst = pool_inst[p];
    e.imm  = pool_imm[p];
    e.halt = (p == 6);
    e.ill  = (p == 7);
    e.chk  = (p < 6);
    return e;
  endfunction

  task automatic set_lane(input int i, input ent_t e);
    lane[i]        = e;
    bus.if_inst[i] = e.inst;
    bus.if_pc[i]   = e.pc;
  endtask

  task automatic check_outputs();
    pkt_t p;
    check("count", 32'(bus.count), 32'(mq.size()));
    check("halted", 32'(bus.halted), 32'(m_halted));
    for (int i = 0; i < WIDTH; i++) begin
      check("ds_valid", 32'(bus.ds_valid[i]), 32'(i < mq.size()));
      if (i < mq.size()) begin
        p = bus.ds_packet[i];
        check("pkt_pc", p.pc, mq[i].pc);
        check("pkt_inst", p.inst, mq[i].inst);
        check("pkt_halt", 32'(p.halt), 32'(mq[i].halt));
        check("pkt_illegal", 32'(p.illegal), 32'(mq[i].ill));
        if (mq[i].chk) check("pkt_imm", p.immediate, mq[i].imm);
      end
    end
  endtask

  // One clock: drive at the falling edge, check combinational accept, then registered outputs.
  task automatic step(input logic [WIDTH-1:0] v, input int tk, input logic fl, output int acc_dut);
    int run, lim, room, exp_acc, avail, exp_take;
    bus.if_valid = v;
    bus.ds_take  = AW'(tk);
    bus.flush    = fl;
    #1;
    run = 0;
    while (run < WIDTH && v[run]) run++;
    lim = WIDTH;
    for (int i = run - 1; i >= 0; i--) if (lane[i].halt || lane[i].ill) lim = i + 1;
    room    = DEPTH - mq.size();
    exp_acc = run;
    if (lim < exp_acc)  exp_acc = lim;
    if (room < exp_acc) exp_acc = room;
    if (m_halted || fl) exp_acc = 0;
    avail    = (mq.size() < WIDTH) ? mq.size() : WIDTH;
    exp_take = (tk < avail) ? tk : avail;
    acc_dut  = int'(bus.if_accept);
    check("if_accept", 32'(bus.if_accept), 32'(exp_acc));
    last_exp_acc = exp_acc;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_halted = 1'b0;
    end else begin
      repeat (exp_take) void'(mq.pop_front());
      for (int i = 0; i < exp_acc; i++) begin
        mq.push_back(lane[i]);
        if (lane[i].halt || lane[i].ill) m_halted = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
    $display("[TB] t=%0t valid=%b take=%0d flush=%0b accept=%0d count=%0d halted=%0b",
             $time, v, tk, fl, acc_dut, bus.count, bus.halted);
  endtask

  initial begin
    int   a;
    int   p;
    int   n;
    pkt_t pk;
    logic [31:0]      pc;
    logic [WIDTH-1:0] v;

    bus.flush    = 1'b0;
    bus.ds_take  = '0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    set_lane(0, make_ent(0, 32'h100));
    set_lane(1, make_ent(1, 32'h104));
    bus.if_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_ds_valid", 32'(bus.ds_valid), 32'd0);
    check("rst_accept", 32'(bus.if_accept), 32'd0);
    rst_n = 1'b1;

    // ADDI + ADD accepted together, ADDI immediate at the head next cycle
    step(2'b11, 0, 1'b0, a);
    check("t1_accept", 32'(a), 32'd2);
    pk = bus.ds_packet[0];
    check("t1_imm", pk.immediate, 32'hFFFFFFFB);
    check("t1_ds_valid", 32'(bus.ds_valid), 32'b11);

    // fill to DEPTH, then full cycle with a take
    pc = 32'h108;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, make_ent(2, pc)); set_lane(1, make_ent(3, pc + 4)); pc += 8;
      step(2'b11, 0, 1'b0, a);
    end
    check("fill_count", 32'(bus.count), 32'd8);
    set_lane(0, make_ent(4, pc)); set_lane(1, make_ent(5, pc + 4));
    step(2'b11, 2, 1'b0, a);
    check("full_accept", 32'(a), 32'd0);
    check("full_count", 32'(bus.count), 32'd6);
    step(2'b11, 0, 1'b0, a);
    check("refill_accept", 32'(a), 32'd2);
    check("refill_count", 32'(bus.count), 32'd8);
    step(2'b00, 1, 1'b1, a);

    // non-contiguous valid
    step(2'b10, 0, 1'b0, a);
    check("gap_accept", 32'(a), 32'd0);

    // WFI fences the lanes behind it until flush
    set_lane(0, make_ent(6, 32'h200)); set_lane(1, make_ent(1, 32'h204));
    step(2'b11, 0, 1'b0, a);
    check("wfi_accept", 32'(a), 32'd1);
    check("wfi_halted", 32'(bus.halted), 32'd1);
    set_lane(0, make_ent(1, 32'h204)); set_lane(1, make_ent(0, 32'h208));
    step(2'b11, 0, 1'b0, a);
    check("fenced_accept", 32'(a), 32'd0);
    step(2'b11, 1, 1'b1, a);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_halted", 32'(bus.halted), 32'd0);
    step(2'b11, 0, 1'b0, a);
    check("resume_accept", 32'(a), 32'd2);

    // all-zero encoding is illegal and fences
    step(2'b00, 0, 1'b1, a);
    set_lane(0, make_ent(7, 32'h300)); set_lane(1, make_ent(0, 32'h304));
    step(2'b11, 0, 1'b0, a);
    pk = bus.ds_packet[0];
    check("ill_flag", 32'(pk.illegal), 32'd1);
    check("ill_halted", 32'(bus.halted), 32'd1);
    step(2'b00, 0, 1'b1, a);

    // random traffic through pointer wrap-around
    pc = 32'h1000;
    for (int cyc = 0; cyc < 300; cyc++) begin
      while (fq.size() < WIDTH) begin
        p = $urandom_range(0, 5);
        if ($urandom_range(0, 19) == 0) p = 6;
        fq.push_back(make_ent(p, pc));
        pc += 4;
      end
      for (int i = 0; i < WIDTH; i++) set_lane(i, fq[i]);
      n = $urandom_range(0, WIDTH);
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      if ($urandom_range(0, 7) == 0) v = WIDTH'($urandom);
      step(v, $urandom_range(0, (1 << AW) - 1),
           ($urandom_range(0, 15) == 0) || (m_halted && ($urandom_range(0, 3) == 0)), a);
      repeat (last_exp_acc) void'(fq.pop_front());
    end

    // asynchronous reset in the middle of traffic
    step(2'b00, 0, 1'b1, a);
    set_lane(0, make_ent(0, 32'h4000)); set_lane(1, make_ent(1, 32'h4004));
    step(2'b11, 0, 1'b0, a);
    check("pre_rst_count", 32'(bus.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_ds_valid", 32'(bus.ds_valid), 32'd0);
    check("mid_rst_accept", 32'(bus.if_accept), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_halted = 1'b0;
    step(2'b11, 0, 1'b0, a);
    check("post_rst_accept", 32'(a), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
